jk_modn_counter_ctrl: RTL and testbench

Sequencer for the `contador_modulo7` datapath. It computes J/K excitation for a bank of W JK flip-flop cells, so the cells count modulo MOD: up or down, with enable, synchronous load with range checking, and a registered wrap (terminal-count) pulse. The default configuration is the modulo-7 counter. It replaces hand-wired excitation logic around individual JK cells.

---
 rtl/jk_ctrl_pkg.sv | 15 +
 rtl/jk_cell.sv | 29 ++
 rtl/jk_modn_counter_ctrl.sv | 92 +++++++++
 tb/tb_jk_modn_counter_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/jk_ctrl_pkg.sv
// rtl/jk_ctrl_pkg.sv - JK mode encodings and excitation helper for the mod-N counter
package jk_ctrl_pkg;

    // Encoded as {j, k}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Set/reset-only excitation: toggle is never requested.
    function automatic logic [1:0] jk_excite(input logic q, input logic nxt);
        return {~q & nxt, q & ~nxt};
    endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop cell with async active-high reset
module jk_cell
    import jk_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic nq
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD: q <= q;
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TGL:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign nq = ~q;

endmodule

// File: rtl/jk_modn_counter_ctrl.sv
// rtl/jk_modn_counter_ctrl.sv - mod-N up/down counter sequencer driving a bank of JK cells
module jk_modn_counter_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int MOD = 7,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] Q,
    output logic [W-1:0] NQ,
    output logic [W-1:0] J,
    output logic [W-1:0] K,
    output logic         tc,
    output logic         load_err
);

    // Range compares use one extra bit since the modulus may equal 2^W.
    localparam logic [W:0]   MODV = (W+1)'(MOD);
    localparam logic [W-1:0] MAXV = W'(MOD - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    if (MOD < 2 || MOD > (1 << W)) begin : g_bad_cfg
        $error("jk_modn_counter_ctrl: MOD out of range for W");
    end

    logic [W-1:0] nxt;
    logic         wrap;
    logic         lerr;
    logic         in_range;
    logic         illegal;

    always_comb begin
        nxt      = Q;
        wrap     = 1'b0;
        in_range = ({1'b0, load_val} < MODV);
        illegal  = ({1'b0, Q} >= MODV);
        lerr     = load & ~in_range;
        if (rst) begin
            nxt = Q;
        end else if (illegal && (load || en)) begin
            // Fault recovery: any active step returns to zero without tc.
            nxt = '0;
        end else if (load) begin
            nxt = in_range ? load_val : '0;
        end else if (en) begin
            if (up) begin
                if (Q == MAXV) begin
                    nxt  = '0;
                    wrap = 1'b1;
                end else begin
                    nxt = Q + ONE;
                end
            end else begin
                if (Q == '0) begin
                    nxt  = MAXV;
                    wrap = 1'b1;
                end else begin
                    nxt = Q - ONE;
                end
            end
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_cell
        assign {J[i], K[i]} = jk_excite(Q[i], nxt[i]);

        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (J[i]),
            .k   (K[i]),
            .q   (Q[i]),
            .nq  (NQ[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tc       <= wrap;
            load_err <= lerr;
        end
    end

endmodule

// File: tb/tb_jk_modn_counter_ctrl.sv
// tb/tb_jk_modn_counter_ctrl.sv - directed self-checking bench for jk_modn_counter_ctrl
module tb_jk_modn_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, load;
    logic [2:0] load_val;
    logic [2:0] q, nq, j, k;
    logic       tc, load_err;

    logic       en8, up8, load8;
    logic [2:0] load_val8;
    logic [2:0] q8, nq8, j8, k8;
    logic       tc8, load_err8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_modn_counter_ctrl #(.MOD(7), .W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .Q(q), .NQ(nq), .J(j), .K(k), .tc(tc), .load_err(load_err)
    );

    jk_modn_counter_ctrl #(.MOD(8), .W(3)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .up(up8), .load(load8), .load_val(load_val8),
        .Q(q8), .NQ(nq8), .J(j8), .K(k8), .tc(tc8), .load_err(load_err8)
    );

    task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariants sampled away from the active edge.
    always @(negedge clk) begin
        chk("jk_overlap", {5'd0, j & k}, 8'd0);
        chk("q_in_range", {7'd0, (q < 3'd7)}, 8'd1);
        chk("nq_compl", {5'd0, nq}, {5'd0, ~q});
        chk("jk8_overlap", {5'd0, j8 & k8}, 8'd0);
    end

    initial begin
        logic [2:0] exp_q;
        logic [2:0] down_seq [4];
        down_seq[0] = 3'd1; down_seq[1] = 3'd0; down_seq[2] = 3'd6; down_seq[3] = 3'd5;

        rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 3'd0;
        en8 = 1'b0; up8 = 1'b1; load8 = 1'b0; load_val8 = 3'd0;
        #12;
        chk("rst_q", {5'd0, q}, 8'd0);
        chk("rst_nq", {5'd0, nq}, 8'd7);
        chk("rst_tc", {7'd0, tc}, 8'd0);
        chk("rst_lerr", {7'd0, load_err}, 8'd0);
        chk("rst_j", {5'd0, j}, 8'd0);
        chk("rst_k", {5'd0, k}, 8'd0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_q = 3'((i + 1) % 7);
            chk("up_q", {5'd0, q}, {5'd0, exp_q});
            chk("up_nq", {5'd0, nq}, {5'd0, ~exp_q});
            chk("up_tc", {7'd0, tc}, {7'd0, (exp_q == 3'd0)});
        end

        up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dn_q", {5'd0, q}, {5'd0, down_seq[i]});
            chk("dn_tc", {7'd0, tc}, {7'd0, (i == 2)});
        end

        // Q=5 stepping down to 4: only bit0 clears.
        #1;
        chk("dn_j", {5'd0, j}, 8'd0);
        chk("dn_k", {5'd0, k}, 8'd1);

        load = 1'b1; load_val = 3'd0;
        tick();
        chk("ld0_q", {5'd0, q}, 8'd0);
        chk("ld0_tc", {7'd0, tc}, 8'd0);

        // Load during a down-wrap condition at Q=0: load wins, no tc.
        load_val = 3'd5;
        tick();
        chk("ld5_q", {5'd0, q}, 8'd5);
        chk("ld5_tc", {7'd0, tc}, 8'd0);
        chk("ld5_lerr", {7'd0, load_err}, 8'd0);

        load_val = 3'd7;
        #1;
        chk("ld7_j", {5'd0, j}, 8'd0);
        chk("ld7_k", {5'd0, k}, 8'd5);
        tick();
        chk("ld7_q", {5'd0, q}, 8'd0);
        chk("ld7_lerr", {7'd0, load_err}, 8'd1);

        load = 1'b0; en = 1'b0;
        tick();
        chk("lerr_clr", {7'd0, load_err}, 8'd0);
        chk("lerr_q", {5'd0, q}, 8'd0);

        load = 1'b1; load_val = 3'd3;
        tick();
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            up = i[0];
            load_val = 3'(i);
            #1;
            chk("hold_j", {5'd0, j}, 8'd0);
            chk("hold_k", {5'd0, k}, 8'd0);
            tick();
            chk("hold_q", {5'd0, q}, 8'd3);
            chk("hold_tc", {7'd0, tc | load_err}, 8'd0);
        end

        // Direction change at the top boundary.
        load = 1'b1; load_val = 3'd6;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        chk("dir_q", {5'd0, q}, 8'd5);
        chk("dir_tc", {7'd0, tc}, 8'd0);

        // Async reset with a tc pulse in flight.
        load = 1'b1; load_val = 3'd6;
        tick();
        load = 1'b0; up = 1'b1;
        tick();
        chk("pre_rst_q", {5'd0, q}, 8'd0);
        chk("pre_rst_tc", {7'd0, tc}, 8'd1);
        load = 1'b1; load_val = 3'd4;
        tick();
        load = 1'b0;
        tick();
        chk("pre_rst_q5", {5'd0, q}, 8'd5);
        load = 1'b1; load_val = 3'd6;
        tick();
        load = 1'b0;
        tick();
        chk("pend_tc", {7'd0, tc}, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_q", {5'd0, q}, 8'd0);
        chk("arst_tc", {7'd0, tc}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("resume_q", {5'd0, q}, 8'd1);
        chk("resume_tc", {7'd0, tc}, 8'd0);
        en = 1'b0;

        // Power-of-two modulus instance: 7 is legal and wraps to 0 with tc.
        load8 = 1'b1; load_val8 = 3'd7;
        tick();
        chk("m8_ld_q", {5'd0, q8}, 8'd7);
        chk("m8_ld_lerr", {7'd0, load_err8}, 8'd0);
        load8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
        tick();
        chk("m8_wrap_q", {5'd0, q8}, 8'd0);
        chk("m8_wrap_tc", {7'd0, tc8}, 8'd1);
        tick();
        chk("m8_next_q", {5'd0, q8}, 8'd1);
        chk("m8_next_tc", {7'd0, tc8}, 8'd0);
        up8 = 1'b0;
        tick();
        tick();
        chk("m8_dn_q", {5'd0, q8}, 8'd7);
        chk("m8_dn_tc", {7'd0, tc8}, 8'd1);
        en8 = 1'b0;

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
